// File: rtl/freq_gate_counter.sv
// Gated frequency counter: counts clk_x_in rising edges per GATE_CYCLES window.
// Ports: clk_ref_in/reset_in, clk_x_in, count_out/overflow_out, valid_out/ack_in, missed_out[, bcd_out].
// Optional BCD output: define FREQ_CNT_BCD_EN.
module freq_gate_counter #(
  parameter int GATE_CYCLES = 10000000,
  parameter int CNT_W       = 24,
  parameter int DIGITS      = 8
) (
  input  logic             clk_ref_in,
  input  logic             reset_in,
  input  logic             clk_x_in,
  input  logic             ack_in,
  output logic [CNT_W-1:0] count_out,
  output logic             overflow_out,
  output logic             valid_out,
  output logic             missed_out
`ifdef FREQ_CNT_BCD_EN
  ,
  output logic [4*DIGITS-1:0] bcd_out
`endif
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  // Conversion must finish before the next window closes.
  if (DIGITS < 1 || GATE_CYCLES < CNT_W + 3) begin : g_bad_cfg
    $error("freq_gate_counter: illegal parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    PUBLISH
`ifdef FREQ_CNT_BCD_EN
    ,
    CONVERT
`endif
  } state_t;

  state_t state, state_nxt;

  logic             x_meta, x_sync, x_hist;
  logic             x_edge;
  logic [GW-1:0]    gate_cnt;
  logic             counting, win_first, win_last;
  logic [CNT_W-1:0] edge_cnt, cnt_inc;
  logic             cnt_max, win_ovf, fin_ovf;
  logic [CNT_W-1:0] cap_cnt;
  logic             cap_ovf;
  logic             publish;

  always_ff @(posedge clk_ref_in or posedge reset_in) begin
    if (reset_in) begin
      x_meta <= 1'b0;
      x_sync <= 1'b0;
      x_hist <= 1'b0;
    end else begin
      x_meta <= clk_x_in;
      x_sync <= x_meta;
      x_hist <= x_sync;
    end
  end

  assign x_edge = x_sync & ~x_hist;

  assign counting  = (state != IDLE);
  assign win_first = counting && (gate_cnt == '0);
  assign win_last  = counting && (gate_cnt == GATE_LAST);
  assign publish   = (state == PUBLISH);

  always_ff @(posedge clk_ref_in or posedge reset_in) begin
    if (reset_in) begin
      gate_cnt <= '0;
    end else if (counting) begin
      gate_cnt <= win_last ? '0 : gate_cnt + GW'(1);
    end
  end

  assign cnt_max = (edge_cnt == '1);
  assign cnt_inc = (x_edge && !cnt_max) ? edge_cnt + CNT_W'(1)
                                        : edge_cnt;
  assign fin_ovf = win_ovf | (x_edge & cnt_max);

  // An edge on the first window cycle already belongs to the new window.
  always_ff @(posedge clk_ref_in or posedge reset_in) begin
    if (reset_in) begin
      edge_cnt <= '0;
      win_ovf  <= 1'b0;
    end else if (win_first) begin
      edge_cnt <= CNT_W'(x_edge);
      win_ovf  <= 1'b0;
    end else if (counting) begin
      edge_cnt <= cnt_inc;
      win_ovf  <= fin_ovf;
    end
  end

  // Result is held here while the next window is already counting.
  always_ff @(posedge clk_ref_in or posedge reset_in) begin
    if (reset_in) begin
      cap_cnt <= '0;
      cap_ovf <= 1'b0;
    end else if (win_last) begin
      cap_cnt <= cnt_inc;
      cap_ovf <= fin_ovf;
    end
  end

`ifdef FREQ_CNT_BCD_EN
  localparam int CVW = $clog2(CNT_W + 1);

  logic [CNT_W-1:0]    conv_bin;
  logic [4*DIGITS-1:0] conv_bcd, bcd_adj;
  logic [CVW-1:0]      conv_cnt;
  logic                conv_done;

  assign conv_done = (conv_cnt == CVW'(CNT_W - 1));

  always_comb begin
    bcd_adj = conv_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (conv_bcd[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = conv_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  // Shift-add-3; digits beyond DIGITS fall off the top.
  always_ff @(posedge clk_ref_in or posedge reset_in) begin
    if (reset_in) begin
      conv_bin <= '0;
      conv_bcd <= '0;
      conv_cnt <= '0;
    end else if (win_last) begin
      conv_bin <= cnt_inc;
      conv_bcd <= '0;
      conv_cnt <= '0;
    end else if (state == CONVERT) begin
      conv_bin <= {conv_bin[CNT_W-2:0], 1'b0};
      conv_bcd <= {bcd_adj[4*DIGITS-2:0], conv_bin[CNT_W-1]};
      conv_cnt <= conv_cnt + CVW'(1);
    end
  end

  always_ff @(posedge clk_ref_in or posedge reset_in) begin
    if (reset_in) begin
      bcd_out <= '0;
    end else if (publish) begin
      bcd_out <= conv_bcd;
    end
  end
`endif

  always_ff @(posedge clk_ref_in or posedge reset_in) begin
    if (reset_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = GATE;
      GATE: begin
        if (win_last) begin
`ifdef FREQ_CNT_BCD_EN
          state_nxt = CONVERT;
`else
          state_nxt = PUBLISH;
`endif
        end
      end
`ifdef FREQ_CNT_BCD_EN
      CONVERT: begin
        if (conv_done) begin
          state_nxt = PUBLISH;
        end
      end
`endif
      PUBLISH: state_nxt = GATE;
      default: state_nxt = IDLE;
    endcase
  end

  // A publish wins over a coincident ack.
  always_ff @(posedge clk_ref_in or posedge reset_in) begin
    if (reset_in) begin
      count_out    <= '0;
      overflow_out <= 1'b0;
      valid_out    <= 1'b0;
      missed_out   <= 1'b0;
    end else if (publish) begin
      count_out    <= cap_cnt;
      overflow_out <= cap_ovf;
      valid_out    <= 1'b1;
      if (valid_out && !ack_in) begin
        missed_out <= 1'b1;
      end
    end else if (valid_out && ack_in) begin
      valid_out  <= 1'b0;
      missed_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Scoreboard bench for freq_gate_counter.
// Expectations are queued by cycle; a negedge monitor pops and compares.
module tb_freq_gate_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_x = 1'b0;
  logic run = 1'b1;
  logic ack = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Period-4 input, 2 high / 2 low; rising when cyc % 4 == 2.
  always @(posedge clk) begin
    #1;
    clk_x = run & cyc[1];
  end

  typedef struct {
    int          at;
    logic [23:0] cnt_a;
    logic        ovf_a;
    logic [3:0]  cnt_b;
    logic        ovf_b;
    logic        vld;
    logic        mis;
    logic [31:0] bcd;
  } exp_t;

  exp_t sbq[$];

  task automatic push(input int at, input logic [23:0] ca,
                      input logic oa, input logic [3:0] cb,
                      input logic ob, input logic v, input logic m,
                      input logic [31:0] b);
    exp_t e;
    e.at = at; e.cnt_a = ca; e.ovf_a = oa;
    e.cnt_b = cb; e.ovf_b = ob;
    e.vld = v; e.mis = m; e.bcd = b;
    sbq.push_back(e);
  endtask

  task automatic chk(input string nm, input int at,
                     input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h want %0h",
                  nm, at, act, req);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_pulse(input int n);
    wait_cyc(n);
    ack = 1'b1;
    wait_cyc(n + 1);
    ack = 1'b0;
  endtask

`ifdef FREQ_CNT_BCD_EN
  logic [23:0] cnt_c;
  logic        ovf_c, vld_c, mis_c;
  logic [31:0] bcd_c;

  freq_gate_counter #(
    .GATE_CYCLES(1000), .CNT_W(24), .DIGITS(8)
  ) dut_c (
    .clk_ref_in(clk), .reset_in(rst), .clk_x_in(clk_x),
    .ack_in(ack), .count_out(cnt_c), .overflow_out(ovf_c),
    .valid_out(vld_c), .missed_out(mis_c), .bcd_out(bcd_c)
  );

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].at <= cyc) begin
        e = sbq.pop_front();
        if (e.at < cyc) begin
          chk("late", cyc, 32'(cyc), 32'(e.at));
        end else begin
          chk("count", cyc, 32'(cnt_c), 32'(e.cnt_a));
          chk("bcd", cyc, bcd_c, e.bcd);
          chk("ovf", cyc, 32'(ovf_c), 32'(e.ovf_a));
          chk("valid", cyc, 32'(vld_c), 32'(e.vld));
          chk("missed", cyc, 32'(mis_c), 32'(e.mis));
        end
      end
    end
  end

  initial begin
    wait_cyc(4);
    rst = 1'b0;
    push(1029, 24'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    push(1030, 24'd250, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h250);
    push(2030, 24'd250, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 32'h250);
    wait_cyc(2040);
    if (sbq.size() != 0) chk("drain", cyc, 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
`else
  logic [23:0] cnt_a;
  logic [3:0]  cnt_b;
  logic        ovf_a, vld_a, mis_a;
  logic        ovf_b, vld_b, mis_b;

  freq_gate_counter #(
    .GATE_CYCLES(100), .CNT_W(24), .DIGITS(8)
  ) dut_a (
    .clk_ref_in(clk), .reset_in(rst), .clk_x_in(clk_x),
    .ack_in(ack), .count_out(cnt_a), .overflow_out(ovf_a),
    .valid_out(vld_a), .missed_out(mis_a)
  );

  freq_gate_counter #(
    .GATE_CYCLES(100), .CNT_W(4), .DIGITS(2)
  ) dut_b (
    .clk_ref_in(clk), .reset_in(rst), .clk_x_in(clk_x),
    .ack_in(ack), .count_out(cnt_b), .overflow_out(ovf_b),
    .valid_out(vld_b), .missed_out(mis_b)
  );

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].at <= cyc) begin
        e = sbq.pop_front();
        if (e.at < cyc) begin
          chk("late", cyc, 32'(cyc), 32'(e.at));
        end else begin
          chk("a_count", cyc, 32'(cnt_a), 32'(e.cnt_a));
          chk("a_ovf", cyc, 32'(ovf_a), 32'(e.ovf_a));
          chk("a_valid", cyc, 32'(vld_a), 32'(e.vld));
          chk("a_missed", cyc, 32'(mis_a), 32'(e.mis));
          chk("b_count", cyc, 32'(cnt_b), 32'(e.cnt_b));
          chk("b_ovf", cyc, 32'(ovf_b), 32'(e.ovf_b));
          chk("b_valid", cyc, 32'(vld_b), 32'(e.vld));
          chk("b_missed", cyc, 32'(mis_b), 32'(e.mis));
        end
      end
    end
  end

  initial begin
    wait_cyc(4);
    rst = 1'b0;
    // window 0: 25 edges; 4-bit copy saturates
    push(106, 24'd25, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0, 32'h0);
    push(155, 24'd25, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 32'h0);
    ack_pulse(154);
    // window 1: input stops early, 24 edges, left unacked
    wait_cyc(199);
    run = 1'b0;
    push(206, 24'd24, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0, 32'h0);
    // window 2: no edges, overwrites unacked result
    wait_cyc(304);
    run = 1'b1;
    push(306, 24'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 32'h0);
    push(355, 24'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    ack_pulse(354);
    // ack with nothing pending is ignored
    push(381, 24'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    ack_pulse(380);
    // window 3 then window 4 with ack on the publish cycle
    push(406, 24'd25, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0, 32'h0);
    push(506, 24'd25, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0, 32'h0);
    push(507, 24'd25, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0, 32'h0);
    ack_pulse(505);
    // mid-window reset clears outputs at once
    push(550, 24'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    push(552, 24'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    wait_cyc(550);
    rst = 1'b1;
    wait_cyc(553);
    rst = 1'b0;
    // first result lands GATE_CYCLES+2 cycles after release
    push(654, 24'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    push(655, 24'd25, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0, 32'h0);
    wait_cyc(665);
    if (sbq.size() != 0) chk("drain", cyc, 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
`endif

endmodule
